// File: rtl/ioncontrol_counter_pkg.sv
// rtl/ioncontrol_counter_pkg.sv - shared types and constants for the gated event counter
package ioncontrol_counter_pkg;

  localparam int COUNT_WIDTH_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage

// File: rtl/gated_event_counter_if.sv
// rtl/gated_event_counter_if.sv - result handshake bundle; duration_data present with GATED_COUNTER_DURATION_EN
interface gated_event_counter_if
  import ioncontrol_counter_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) ();

  logic [COUNT_WIDTH-1:0] count_data;
  logic                   count_valid;
  logic                   count_ready;
  logic                   saturated;
`ifdef GATED_COUNTER_DURATION_EN
  logic [COUNT_WIDTH-1:0] duration_data;

  modport master (output count_data, count_valid, saturated, duration_data, input count_ready);
  modport slave  (input count_data, count_valid, saturated, duration_data, output count_ready);
`else
  modport master (output count_data, count_valid, saturated, input count_ready);
  modport slave  (input count_data, count_valid, saturated, output count_ready);
`endif

endinterface

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - two-flop synchronizer plus rising-edge detector for the detector pulse
module pulse_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic pulse_event
);

  // [0],[1] are the synchronizer pair, [2] is the previous synchronized value for edge detection
  logic [2:0] sync_q;

  // shift the asynchronous pin through the synchronizer and edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], pulse_in};
    end
  end

  assign pulse_event = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/gated_event_counter.sv
// rtl/gated_event_counter.sv - counts detector events per gate window; GATED_COUNTER_DURATION_EN adds window length
module gated_event_counter
  import ioncontrol_counter_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gate,
  input  logic                  pulse_in,
  output logic                  overrun,
  input  logic                  clear_overrun,
  gated_event_counter_if.master res
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state;
  state_e                 state_nxt;
  logic                   gate_r;
  logic                   ev;
  logic                   start;
  logic                   latch;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] acc_nxt;
  logic                   sat_r;
  logic                   load;
`ifdef GATED_COUNTER_DURATION_EN
  logic [COUNT_WIDTH-1:0] dur;
  logic [COUNT_WIDTH-1:0] dur_nxt;
`endif

  pulse_sync_edge u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse_in    (pulse_in),
    .pulse_event (ev)
  );

  // register the gate once so the window aligns to a clean clk-domain signal
  always_ff @(posedge clk) begin
    if (!rst_n) gate_r <= 1'b0;
    else        gate_r <= gate;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // window open/close decode: start on the first gated cycle, latch on the first ungated one
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: if (gate_r) begin
        state_nxt = COUNT;
        start     = 1'b1;
      end
      COUNT: if (!gate_r) begin
        state_nxt = IDLE;
        latch     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // next accumulator value: restart with the current event, else saturating increment while gated
  always_comb begin
    acc_nxt = acc;
    if (start) begin
      acc_nxt = COUNT_WIDTH'(ev);
    end else if (state == COUNT && gate_r && ev && acc != CNT_MAX) begin
      acc_nxt = acc + COUNT_WIDTH'(1);
    end
  end

  // accumulator and its saturation bit, which tracks whether the count has reached all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      sat_r <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      sat_r <= (acc_nxt == CNT_MAX);
    end
  end

`ifdef GATED_COUNTER_DURATION_EN
  // next window-length value, saturating like the event count
  always_comb begin
    dur_nxt = dur;
    if (start) begin
      dur_nxt = COUNT_WIDTH'(1);
    end else if (state == COUNT && gate_r && dur != CNT_MAX) begin
      dur_nxt = dur + COUNT_WIDTH'(1);
    end
  end

  // window-length counter
  always_ff @(posedge clk) begin
    if (!rst_n) dur <= '0;
    else        dur <= dur_nxt;
  end
`endif

  // a new result is accepted when the slot is empty or is being emptied this cycle
  assign load = latch && (!res.count_valid || res.count_ready);

  // result register, valid handshake and sticky overrun (a set beats a clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res.count_data  <= '0;
      res.count_valid <= 1'b0;
      res.saturated   <= 1'b0;
`ifdef GATED_COUNTER_DURATION_EN
      res.duration_data <= '0;
`endif
      overrun         <= 1'b0;
    end else begin
      if (load) begin
        res.count_data  <= acc;
        res.saturated   <= sat_r;
        res.count_valid <= 1'b1;
`ifdef GATED_COUNTER_DURATION_EN
        res.duration_data <= dur;
`endif
      end else if (res.count_valid && res.count_ready) begin
        res.count_valid <= 1'b0;
      end
      if (latch && !load)      overrun <= 1'b1;
      else if (clear_overrun)  overrun <= 1'b0;
    end
  end

endmodule
